// File: rtl/sha3_byte_feeder.sv
// rtl/sha3_byte_feeder.sv - packs a message byte stream into big-endian 32-bit padder words
// Emits full words, a terminating partial/empty word, then waits for the digest.
module sha3_byte_feeder #(
  parameter int LEN_W     = 16,
  parameter bit WAIT_DONE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  input  logic             flush,
  input  logic             buffer_full,
  output logic [31:0]      in,
  output logic             in_ready,
  output logic             is_last,
  output logic [1:0]       byte_num,
  input  logic             hash_done,
  output logic             busy,
  output logic [LEN_W-1:0] msg_len
);

  typedef enum logic [1:0] {FILL, EMIT, EMIT_LAST, WAIT_HASH} state_t;

  state_t           state, state_next;
  logic [1:0]       idx;
  logic [31:0]      word;
  logic [1:0]       last_bnum;
  logic             pend_empty;
  logic             busy_q;
  logic [LEN_W-1:0] len_q;

  logic accept, flush_take, emitting, strobe;

  always_comb begin
    accept     = 1'b0;
    flush_take = 1'b0;
    emitting   = 1'b0;
    strobe     = 1'b0;
    state_next = state;
    case (state)
      FILL: begin
        accept     = s_valid;
        // an accepted byte takes priority; its s_last decides how the message ends
        flush_take = flush & ~s_valid;
        if (accept) begin
          if (idx == 2'd3)  state_next = EMIT;
          else if (s_last)  state_next = EMIT_LAST;
        end else if (flush_take) begin
          state_next = EMIT_LAST;
        end
      end
      EMIT: begin
        emitting = 1'b1;
        strobe   = ~buffer_full;
        if (strobe) state_next = pend_empty ? EMIT_LAST : FILL;
      end
      EMIT_LAST: begin
        emitting = 1'b1;
        strobe   = ~buffer_full;
        if (strobe) state_next = WAIT_DONE ? WAIT_HASH : FILL;
      end
      WAIT_HASH: begin
        if (hash_done) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= FILL;
      idx        <= 2'd0;
      word       <= 32'd0;
      last_bnum  <= 2'd0;
      pend_empty <= 1'b0;
      busy_q     <= 1'b0;
      len_q      <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        word   <= word | ({s_data, 24'd0} >> {idx, 3'b000});
        idx    <= idx + 2'd1;
        len_q  <= busy_q ? len_q + 1'b1 : LEN_W'(1);
        busy_q <= 1'b1;
        if (idx == 2'd3) begin
          pend_empty <= s_last;
          last_bnum  <= 2'd0;
        end else begin
          last_bnum  <= idx + 2'd1;
        end
      end
      if (flush_take) begin
        last_bnum <= idx;
        busy_q    <= 1'b1;
        if (!busy_q) len_q <= '0;
      end
      if (strobe) begin
        // clearing after every strobe keeps unused lanes of the next partial word zero
        word       <= 32'd0;
        pend_empty <= 1'b0;
        if (state == EMIT_LAST) begin
          idx <= 2'd0;
          if (!WAIT_DONE) busy_q <= 1'b0;
        end
      end
      if (state == WAIT_HASH && hash_done) begin
        busy_q <= 1'b0;
        idx    <= 2'd0;
        word   <= 32'd0;
      end
    end
  end

  assign s_ready  = (state == FILL);
  assign in_ready = strobe;
  assign in       = emitting ? word : 32'd0;
  assign is_last  = (state == EMIT_LAST);
  assign byte_num = is_last ? last_bnum : 2'd0;
  assign busy     = busy_q;
  assign msg_len  = len_q;

endmodule

// File: tb/tb_sha3_byte_feeder.sv
// tb/tb_sha3_byte_feeder.sv - cycle-table and directed checks for sha3_byte_feeder
module tb_sha3_byte_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid, s_last, s_ready, flush, buffer_full;
  logic [31:0] in;
  logic        in_ready, is_last, hash_done, busy;
  logic [1:0]  byte_num;
  logic [15:0] msg_len;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sha3_byte_feeder #(.LEN_W(16), .WAIT_DONE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .flush(flush), .buffer_full(buffer_full), .in(in),
    .in_ready(in_ready), .is_last(is_last), .byte_num(byte_num), .hash_done(hash_done),
    .busy(busy), .msg_len(msg_len)
  );

  typedef struct {
    logic [7:0]  d;
    logic        v, l, f, bf, hd;
    logic        sr, ir;
    logic [31:0] w;
    logic        il;
    logic [1:0]  bn;
    logic        bz;
    logic [15:0] ml;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [7:0] d, logic v, logic l, logic f, logic bf, logic hd,
                              logic sr, logic ir, logic [31:0] w, logic il, logic [1:0] bn,
                              logic bz, logic [15:0] ml);
    vec_t t;
    t.d = d; t.v = v; t.l = l; t.f = f; t.bf = bf; t.hd = hd;
    t.sr = sr; t.ir = ir; t.w = w; t.il = il; t.bn = bn; t.bz = bz; t.ml = ml;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // inputs change on the falling edge; outputs are sampled 1ns later
  task automatic cyc(input logic [7:0] d, input logic v, input logic l, input logic f,
                     input logic bf, input logic hd);
    @(negedge clk);
    s_data = d; s_valid = v; s_last = l; flush = f; buffer_full = bf; hash_done = hd;
    #1;
  endtask

  task automatic chk_all(input string tag, input logic sr, input logic ir, input logic [31:0] w,
                         input logic il, input logic [1:0] bn, input logic bz, input logic [15:0] ml);
    chk({tag, ".s_ready"},  {31'd0, s_ready},  {31'd0, sr});
    chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, ir});
    chk({tag, ".in"},       in,                w);
    chk({tag, ".is_last"},  {31'd0, is_last},  {31'd0, il});
    chk({tag, ".byte_num"}, {30'd0, byte_num}, {30'd0, bn});
    chk({tag, ".busy"},     {31'd0, busy},     {31'd0, bz});
    chk({tag, ".msg_len"},  {16'd0, msg_len},  {16'd0, ml});
  endtask

  initial begin
    rst_n = 1'b0;
    s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0; flush = 1'b0;
    buffer_full = 1'b0; hash_done = 1'b0;

    // 11 22 33 44 | 55 66(last)
    vecs.push_back(mk(8'h11,1,0,0,0,0, 1,0,32'h0,0,0,0,0));
    vecs.push_back(mk(8'h22,1,0,0,0,0, 1,0,32'h0,0,0,1,1));
    vecs.push_back(mk(8'h33,1,0,0,0,0, 1,0,32'h0,0,0,1,2));
    vecs.push_back(mk(8'h44,1,0,0,0,0, 1,0,32'h0,0,0,1,3));
    vecs.push_back(mk(8'h55,1,0,0,0,0, 0,1,32'h11223344,0,0,1,4));
    vecs.push_back(mk(8'h55,1,0,0,0,0, 1,0,32'h0,0,0,1,4));
    vecs.push_back(mk(8'h66,1,1,0,0,0, 1,0,32'h0,0,0,1,5));
    vecs.push_back(mk(8'h00,0,0,0,0,0, 0,1,32'h55660000,1,2,1,6));
    vecs.push_back(mk(8'h77,1,0,0,0,0, 0,0,32'h0,0,0,1,6));
    vecs.push_back(mk(8'h00,0,0,0,0,1, 0,0,32'h0,0,0,1,6));
    vecs.push_back(mk(8'h00,0,0,0,0,0, 1,0,32'h0,0,0,0,6));
    // AA BB CC DD(last): full word then empty terminator
    vecs.push_back(mk(8'hAA,1,0,0,0,0, 1,0,32'h0,0,0,0,6));
    vecs.push_back(mk(8'hBB,1,0,0,0,0, 1,0,32'h0,0,0,1,1));
    vecs.push_back(mk(8'hCC,1,0,0,0,0, 1,0,32'h0,0,0,1,2));
    vecs.push_back(mk(8'hDD,1,1,0,0,0, 1,0,32'h0,0,0,1,3));
    vecs.push_back(mk(8'h00,0,0,0,0,0, 0,1,32'hAABBCCDD,0,0,1,4));
    vecs.push_back(mk(8'h00,0,0,0,0,0, 0,1,32'h0,1,0,1,4));
    vecs.push_back(mk(8'h00,0,0,0,0,1, 0,0,32'h0,0,0,1,4));
    // empty message via flush
    vecs.push_back(mk(8'h00,0,0,1,0,0, 1,0,32'h0,0,0,0,4));
    vecs.push_back(mk(8'h00,0,0,0,0,0, 0,1,32'h0,1,0,1,0));
    vecs.push_back(mk(8'h00,0,0,0,0,1, 0,0,32'h0,0,0,1,0));
    vecs.push_back(mk(8'h00,0,0,0,0,0, 1,0,32'h0,0,0,0,0));
    // A1 B2 then flush; stray hash_done in FILL is ignored
    vecs.push_back(mk(8'hA1,1,0,0,0,0, 1,0,32'h0,0,0,0,0));
    vecs.push_back(mk(8'hB2,1,0,0,0,1, 1,0,32'h0,0,0,1,1));
    vecs.push_back(mk(8'h00,0,0,1,0,0, 1,0,32'h0,0,0,1,2));
    vecs.push_back(mk(8'h00,0,0,0,0,0, 0,1,32'hA1B20000,1,2,1,2));
    vecs.push_back(mk(8'h00,0,0,0,0,1, 0,0,32'h0,0,0,1,2));
    // flush alongside an accepted byte is ignored
    vecs.push_back(mk(8'hC3,1,0,1,0,0, 1,0,32'h0,0,0,0,2));
    vecs.push_back(mk(8'hD4,1,1,0,0,0, 1,0,32'h0,0,0,1,1));
    vecs.push_back(mk(8'h00,0,0,0,0,0, 0,1,32'hC3D40000,1,2,1,2));
    vecs.push_back(mk(8'h00,0,0,0,0,1, 0,0,32'h0,0,0,1,2));
    vecs.push_back(mk(8'h00,0,0,0,0,0, 1,0,32'h0,0,0,0,2));

    cyc(8'h00,0,0,0,0,0);
    cyc(8'h00,0,0,0,0,0);
    rst_n = 1'b1;
    cyc(8'h00,0,0,0,0,0);
    chk_all("reset", 1,0,32'h0,0,0,0,16'd0);

    foreach (vecs[i]) begin
      cyc(vecs[i].d, vecs[i].v, vecs[i].l, vecs[i].f, vecs[i].bf, vecs[i].hd);
      chk_all($sformatf("vec%0d", i), vecs[i].sr, vecs[i].ir, vecs[i].w, vecs[i].il,
              vecs[i].bn, vecs[i].bz, vecs[i].ml);
    end

    // back-pressure: word held while buffer_full, offered bytes refused
    cyc(8'h01,1,0,0,0,0); cyc(8'h02,1,0,0,0,0); cyc(8'h03,1,0,0,0,0); cyc(8'h04,1,0,0,0,0);
    for (int k = 0; k < 5; k++) begin
      cyc(8'hEE,1,0,0,1,0);
      chk_all($sformatf("hold%0d", k), 0,0,32'h01020304,0,0,1,16'd4);
    end
    cyc(8'hEE,1,0,0,0,0);
    chk_all("hold_release", 0,1,32'h01020304,0,0,1,16'd4);
    cyc(8'h05,1,1,0,0,0);
    chk_all("tail_accept", 1,0,32'h0,0,0,1,16'd4);
    cyc(8'h00,0,0,0,0,0);
    chk_all("tail_word", 0,1,32'h05000000,1,1,1,16'd5);

    // next message blocked until hash_done
    for (int k = 0; k < 3; k++) begin
      cyc(8'h09,1,0,0,0,0);
      chk_all($sformatf("wait%0d", k), 0,0,32'h0,0,0,1,16'd5);
    end
    cyc(8'h09,1,0,0,0,1);
    chk_all("hash_done", 0,0,32'h0,0,0,1,16'd5);
    cyc(8'h09,1,0,0,0,0);
    chk_all("resume", 1,0,32'h0,0,0,0,16'd5);
    cyc(8'h0A,1,1,0,0,0);
    chk_all("resume2", 1,0,32'h0,0,0,1,16'd1);
    cyc(8'h00,0,0,0,0,0);
    chk_all("resume_word", 0,1,32'h090A0000,1,2,1,16'd2);
    cyc(8'h00,0,0,0,0,1);

    // reset mid-message discards the partial word
    cyc(8'h77,1,0,0,0,0); cyc(8'h88,1,0,0,0,0);
    rst_n = 1'b0;
    cyc(8'h00,0,0,0,0,0);
    rst_n = 1'b1;
    cyc(8'h01,1,0,0,0,0);
    chk_all("mid_reset", 1,0,32'h0,0,0,0,16'd0);
    cyc(8'h02,1,0,0,0,0);
    cyc(8'h03,1,1,0,0,0);
    chk_all("post_reset3", 1,0,32'h0,0,0,1,16'd2);
    cyc(8'h00,0,0,0,0,0);
    chk_all("post_reset_word", 0,1,32'h01020300,1,3,1,16'd3);
    cyc(8'h00,0,0,0,0,0);
    chk_all("post_reset_wait", 0,0,32'h0,0,0,1,16'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
